// File: rtl/wb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_stage
// Purpose  : Write-back (final) pipeline stage. Latches one instruction from
//            MEM, resolves its exception vector by fixed priority (with a
//            pending interrupt tagged while the instruction sits in WB), and
//            commits either a GPR/CSR write or an exception/ERTN flush. It is
//            the sole driver of the CSR-file commit interface.
// Ports    : clk, resetn (sync, active-low)
//            ms_*            - instruction payload and handshake from MEM
//            ws_allowin      - WB accepts an instruction (always 1)
//            has_int, csr_rvalue, ex_entry, ertn_entry - from CSR file
//            csr_*, wb_*, ertn_flush - CSR-file commit interface
//            flush, flush_target     - pipeline kill and redirect PC
//            ws_csr_busy     - WB holds a CSR-writing or ERTN instruction
//            rf_*            - GPR write port
//            retire_cnt      - committed-instruction counter (wraps)
//            debug_wb_*      - trace port
// Revision : 1.0 - initial release
// ============================================================================
module wb_commit_stage #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ms_to_ws_valid,
  output logic                ws_allowin,
  input  logic [31:0]         ms_pc,
  input  logic [31:0]         ms_result,
  input  logic                ms_rf_we,
  input  logic [4:0]          ms_rf_waddr,
  input  logic [31:0]         ms_vaddr,
  input  logic                ms_ex_adef,
  input  logic                ms_ex_ine,
  input  logic                ms_ex_sys,
  input  logic                ms_ex_brk,
  input  logic                ms_ex_ale,
  input  logic                ms_ex_adem,
  input  logic                ms_ertn,
  input  logic [1:0]          ms_csr_op,
  input  logic [13:0]         ms_csr_num,
  input  logic [31:0]         ms_csr_wdata,
  input  logic [31:0]         ms_csr_mask,
  input  logic                has_int,
  input  logic [31:0]         csr_rvalue,
  input  logic [31:0]         ex_entry,
  input  logic [31:0]         ertn_entry,
  output logic                csr_re,
  output logic                csr_we,
  output logic [13:0]         csr_num,
  output logic [31:0]         csr_wmask,
  output logic [31:0]         csr_wvalue,
  output logic                wb_ex,
  output logic                ertn_flush,
  output logic [31:0]         wb_csr_pc,
  output logic [31:0]         wb_vaddr,
  output logic [5:0]          wb_ecode,
  output logic [8:0]          wb_esubcode,
  output logic                flush,
  output logic [31:0]         flush_target,
  output logic                ws_csr_busy,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic [RETIRE_W-1:0] retire_cnt,
  output logic [31:0]         debug_wb_pc,
  output logic [3:0]          debug_wb_rf_we,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [31:0]         debug_wb_rf_wdata
);

  // Stage state and latched payload
  logic                r_valid;
  logic [31:0]         r_pc;
  logic [31:0]         r_result;
  logic                r_rf_we;
  logic [4:0]          r_rf_waddr;
  logic [31:0]         r_vaddr;
  logic                r_ex_adef;
  logic                r_ex_ine;
  logic                r_ex_sys;
  logic                r_ex_brk;
  logic                r_ex_ale;
  logic                r_ex_adem;
  logic                r_ertn;
  logic [1:0]          r_csr_op;
  logic [13:0]         r_csr_num;
  logic [31:0]         r_csr_wdata;
  logic [31:0]         r_csr_mask;
  logic [RETIRE_W-1:0] r_retire_cnt;

  logic w_valid;
  logic w_int_hit;
  logic w_ex_any;
  logic w_csr_access;

  // WB never stalls.
  assign ws_allowin = 1'b1;

  // Gating with resetn keeps every strobe quiet during a reset cycle even
  // though the valid register only clears at the following edge.
  assign w_valid      = r_valid & resetn;
  assign w_int_hit    = w_valid & has_int;
  assign w_ex_any     = w_int_hit | r_ex_adef | r_ex_ine | r_ex_sys |
                        r_ex_brk | r_ex_ale | r_ex_adem;
  assign w_csr_access = (r_csr_op != 2'b00);

  assign wb_ex        = w_valid & w_ex_any;
  assign ertn_flush   = w_valid & r_ertn & ~w_ex_any;
  assign flush        = wb_ex | ertn_flush;
  assign flush_target = wb_ex ? ex_entry : ertn_entry;
  assign wb_csr_pc    = r_pc;
  assign wb_vaddr     = r_vaddr;

  // Fixed exception priority; codes read zero when nothing is raised.
  always_comb begin
    wb_ecode    = 6'h00;
    wb_esubcode = 9'h000;
    if (wb_ex) begin
      if (w_int_hit) begin
        wb_ecode = 6'h00;
      end else if (r_ex_adef) begin
        wb_ecode = 6'h08;
      end else if (r_ex_ine) begin
        wb_ecode = 6'h0D;
      end else if (r_ex_sys) begin
        wb_ecode = 6'h0B;
      end else if (r_ex_brk) begin
        wb_ecode = 6'h0C;
      end else if (r_ex_ale) begin
        wb_ecode = 6'h09;
      end else begin
        wb_ecode    = 6'h08;
        wb_esubcode = 9'h001;
      end
    end
  end

  // CSR commit
  assign csr_num     = r_csr_num;
  assign csr_re      = w_valid & w_csr_access;
  assign csr_we      = w_valid & r_csr_op[1] & ~w_ex_any;
  assign csr_wmask   = (r_csr_op == 2'b11) ? r_csr_mask : 32'hFFFF_FFFF;
  assign csr_wvalue  = r_csr_wdata;
  assign ws_csr_busy = w_valid & (r_csr_op[1] | r_ertn);

  // GPR commit: CSR instructions return the pre-write CSR value.
  assign rf_we    = w_valid & r_rf_we & ~w_ex_any;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = w_csr_access ? csr_rvalue : r_result;

  assign retire_cnt        = r_retire_cnt;
  assign debug_wb_pc       = r_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // Valid bit: an instruction arriving during a flush is dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= ms_to_ws_valid & ~flush;
    end
  end

  // Payload is don't-care while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (ms_to_ws_valid & ws_allowin) begin
      r_pc        <= ms_pc;
      r_result    <= ms_result;
      r_rf_we     <= ms_rf_we;
      r_rf_waddr  <= ms_rf_waddr;
      r_vaddr     <= ms_vaddr;
      r_ex_adef   <= ms_ex_adef;
      r_ex_ine    <= ms_ex_ine;
      r_ex_sys    <= ms_ex_sys;
      r_ex_brk    <= ms_ex_brk;
      r_ex_ale    <= ms_ex_ale;
      r_ex_adem   <= ms_ex_adem;
      r_ertn      <= ms_ertn;
      r_csr_op    <= ms_csr_op;
      r_csr_num   <= ms_csr_num;
      r_csr_wdata <= ms_csr_wdata;
      r_csr_mask  <= ms_csr_mask;
    end
  end

  // Retired-instruction counter; ERTN retires, excepting instructions do not.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_retire_cnt <= '0;
    end else if (w_valid & ~w_ex_any) begin
      r_retire_cnt <= r_retire_cnt + RETIRE_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit_stage
// Purpose  : Self-checking bench for wb_commit_stage (RETIRE_W = 4 build).
//            Directed scenarios followed by randomized traffic, all checked
//            against a behavioural model of the WB stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_commit_stage;

  localparam int RW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, ms_to_ws_valid, ws_allowin;
  logic [31:0]   ms_pc, ms_result, ms_vaddr, ms_csr_wdata, ms_csr_mask;
  logic          ms_rf_we, ms_ertn;
  logic [4:0]    ms_rf_waddr;
  logic          ms_ex_adef, ms_ex_ine, ms_ex_sys, ms_ex_brk, ms_ex_ale, ms_ex_adem;
  logic [1:0]    ms_csr_op;
  logic [13:0]   ms_csr_num;
  logic          has_int;
  logic [31:0]   csr_rvalue, ex_entry, ertn_entry;
  logic          csr_re, csr_we, wb_ex, ertn_flush, flush, ws_csr_busy, rf_we;
  logic [13:0]   csr_num;
  logic [31:0]   csr_wmask, csr_wvalue, wb_csr_pc, wb_vaddr, flush_target, rf_wdata;
  logic [5:0]    wb_ecode;
  logic [8:0]    wb_esubcode;
  logic [4:0]    rf_waddr, debug_wb_rf_wnum;
  logic [RW-1:0] retire_cnt;
  logic [31:0]   debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]    debug_wb_rf_we;

  wb_commit_stage #(.RETIRE_W(RW)) dut (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_result(ms_result), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
    .ms_vaddr(ms_vaddr), .ms_ex_adef(ms_ex_adef), .ms_ex_ine(ms_ex_ine), .ms_ex_sys(ms_ex_sys),
    .ms_ex_brk(ms_ex_brk), .ms_ex_ale(ms_ex_ale), .ms_ex_adem(ms_ex_adem), .ms_ertn(ms_ertn),
    .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num), .ms_csr_wdata(ms_csr_wdata),
    .ms_csr_mask(ms_csr_mask), .has_int(has_int), .csr_rvalue(csr_rvalue),
    .ex_entry(ex_entry), .ertn_entry(ertn_entry), .csr_re(csr_re), .csr_we(csr_we),
    .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex),
    .ertn_flush(ertn_flush), .wb_csr_pc(wb_csr_pc), .wb_vaddr(wb_vaddr), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .flush(flush), .flush_target(flush_target),
    .ws_csr_busy(ws_csr_busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // Behavioural model: the instruction held in WB, as a record of MEM inputs.
  typedef struct {
    logic [31:0] pc, result, vaddr, wdata, mask;
    logic        rf_we, ertn;
    logic [4:0]  waddr;
    logic [5:0]  ex;   // {adef, ine, sys, brk, ale, adem}
    logic [1:0]  op;
    logic [13:0] num;
  } instr_t;

  instr_t m_ins;
  bit     m_valid;
  int     m_cnt;
  bit     m_flush;
  int     nvec = 0;
  int     nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the model says the WB stage must do.
  task automatic step();
    bit eff, exany, e_ex, e_ertn, e_csrwe, e_rfwe;
    logic [5:0] ec;
    logic [8:0] es;
    #1;
    eff    = m_valid && resetn;
    exany  = has_int || (m_ins.ex != 6'd0);
    e_ex   = eff && exany;
    e_ertn = eff && m_ins.ertn && !exany;
    m_flush = e_ex || e_ertn;
    e_csrwe = eff && (m_ins.op == 2'd2 || m_ins.op == 2'd3) && !exany;
    e_rfwe  = eff && m_ins.rf_we && !exany;
    ec = 6'h00; es = 9'h000;
    if (e_ex) begin
      if (has_int)            ec = 6'h00;
      else if (m_ins.ex[5])   ec = 6'h08;
      else if (m_ins.ex[4])   ec = 6'h0D;
      else if (m_ins.ex[3])   ec = 6'h0B;
      else if (m_ins.ex[2])   ec = 6'h0C;
      else if (m_ins.ex[1])   ec = 6'h09;
      else begin              ec = 6'h08; es = 9'h001; end
    end
    chk("ws_allowin", 32'(ws_allowin), 32'd1);
    chk("wb_ex", 32'(wb_ex), 32'(e_ex));
    chk("ertn_flush", 32'(ertn_flush), 32'(e_ertn));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("ecode", 32'(wb_ecode), 32'(ec));
    chk("esubcode", 32'(wb_esubcode), 32'(es));
    chk("csr_we", 32'(csr_we), 32'(e_csrwe));
    chk("csr_re", 32'(csr_re), 32'(eff && m_ins.op != 2'd0));
    chk("rf_we", 32'(rf_we), 32'(e_rfwe));
    chk("dbg_rf_we", 32'(debug_wb_rf_we), e_rfwe ? 32'hF : 32'h0);
    chk("csr_busy", 32'(ws_csr_busy), 32'(eff && (m_ins.op >= 2'd2 || m_ins.ertn)));
    chk("retire_cnt", 32'(retire_cnt), 32'(m_cnt % (1 << RW)));
    if (m_flush) chk("flush_target", flush_target, e_ex ? ex_entry : ertn_entry);
    if (eff) begin
      chk("csr_num", 32'(csr_num), 32'(m_ins.num));
      chk("csr_wmask", csr_wmask, (m_ins.op == 2'd3) ? m_ins.mask : 32'hFFFF_FFFF);
      chk("csr_wvalue", csr_wvalue, m_ins.wdata);
      chk("wb_csr_pc", wb_csr_pc, m_ins.pc);
      chk("wb_vaddr", wb_vaddr, m_ins.vaddr);
      chk("rf_waddr", 32'(rf_waddr), 32'(m_ins.waddr));
      chk("rf_wdata", rf_wdata, (m_ins.op != 2'd0) ? csr_rvalue : m_ins.result);
      chk("dbg_pc", debug_wb_pc, m_ins.pc);
      chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(m_ins.waddr));
      chk("dbg_wdata", debug_wb_rf_wdata, (m_ins.op != 2'd0) ? csr_rvalue : m_ins.result);
    end
  endtask

  // Clock edge: advance the model with the inputs that were present.
  task automatic adv();
    bit exany;
    exany = has_int || (m_ins.ex != 6'd0);
    @(posedge clk);
    if (!resetn) begin
      m_valid = 1'b0;
      m_cnt   = 0;
    end else begin
      if (m_valid && !exany) m_cnt++;
      m_valid = ms_to_ws_valid && !m_flush;
    end
    if (ms_to_ws_valid) begin
      m_ins.pc = ms_pc;  m_ins.result = ms_result;  m_ins.vaddr = ms_vaddr;
      m_ins.wdata = ms_csr_wdata;  m_ins.mask = ms_csr_mask;  m_ins.rf_we = ms_rf_we;
      m_ins.ertn = ms_ertn;  m_ins.waddr = ms_rf_waddr;  m_ins.op = ms_csr_op;
      m_ins.num = ms_csr_num;
      m_ins.ex = {ms_ex_adef, ms_ex_ine, ms_ex_sys, ms_ex_brk, ms_ex_ale, ms_ex_adem};
    end
    @(negedge clk);
  endtask

  task automatic tick();
    step();
    adv();
  endtask

  task automatic clr();
    ms_to_ws_valid = 0; ms_pc = 32'h1C00_0000; ms_result = 32'h0; ms_rf_we = 0;
    ms_rf_waddr = 5'd0; ms_vaddr = 32'h0; ms_ertn = 0; ms_csr_op = 2'd0;
    ms_csr_num = 14'd0; ms_csr_wdata = 32'h0; ms_csr_mask = 32'h0;
    {ms_ex_adef, ms_ex_ine, ms_ex_sys, ms_ex_brk, ms_ex_ale, ms_ex_adem} = 6'd0;
    has_int = 0;
  endtask

  task automatic rand_in();
    ms_to_ws_valid = ($urandom_range(0, 4) != 0);
    ms_pc = $urandom;  ms_result = $urandom;  ms_vaddr = $urandom;
    ms_rf_we = 1'($urandom);  ms_rf_waddr = 5'($urandom);
    ms_csr_op = 2'($urandom);  ms_csr_num = 14'($urandom);
    ms_csr_wdata = $urandom;  ms_csr_mask = $urandom;
    ms_ertn    = ($urandom_range(0, 7) == 0);
    ms_ex_adef = ($urandom_range(0, 11) == 0);
    ms_ex_ine  = ($urandom_range(0, 11) == 0);
    ms_ex_sys  = ($urandom_range(0, 11) == 0);
    ms_ex_brk  = ($urandom_range(0, 11) == 0);
    ms_ex_ale  = ($urandom_range(0, 11) == 0);
    ms_ex_adem = ($urandom_range(0, 11) == 0);
    has_int    = ($urandom_range(0, 9) == 0);
    resetn     = ($urandom_range(0, 39) != 0);
    csr_rvalue = $urandom;  ex_entry = $urandom;  ertn_entry = $urandom;
  endtask

  initial begin
    m_valid = 0; m_cnt = 0; m_flush = 0;
    m_ins = '{pc: 0, result: 0, vaddr: 0, wdata: 0, mask: 0, rf_we: 0, ertn: 0,
              waddr: 0, ex: 0, op: 0, num: 0};
    clr();
    resetn = 0; csr_rvalue = 32'h0; ex_entry = 32'h1C00_8000; ertn_entry = 32'h1C00_0200;
    @(posedge clk); @(negedge clk);
    tick();                                   // reset state
    resetn = 1;
    tick();

    // csrwr 0x30 <- 0x1234, old value 0xAA into GPR
    ms_to_ws_valid = 1; ms_csr_op = 2'd2; ms_csr_num = 14'h30;
    ms_csr_wdata = 32'h1234; ms_rf_we = 1; ms_rf_waddr = 5'd4;
    tick();
    clr(); csr_rvalue = 32'hAA;
    step();
    chk("csrwr_wvalue", csr_wvalue, 32'h1234);
    chk("csrwr_rf_wdata", rf_wdata, 32'hAA);
    adv();

    // csrxchg with mask
    ms_to_ws_valid = 1; ms_csr_op = 2'd3; ms_csr_mask = 32'h0000_FF00; ms_csr_wdata = 32'h5A5A;
    ms_rf_we = 1; ms_rf_waddr = 5'd7;
    tick();
    clr();
    step();
    chk("xchg_wmask", csr_wmask, 32'h0000_FF00);
    adv();

    // SYS + ALE: SYS wins
    ms_to_ws_valid = 1; ms_pc = 32'h1C00_0100; ms_ex_sys = 1; ms_ex_ale = 1; ms_rf_we = 1;
    tick();
    clr();
    step();
    chk("sys_ecode", 32'(wb_ecode), 32'h0B);
    adv();

    // ADEM load with pending interrupt: INT wins
    ms_to_ws_valid = 1; ms_pc = 32'h1C00_0104; ms_vaddr = 32'h8003; ms_ex_adem = 1; ms_rf_we = 1;
    tick();
    clr(); has_int = 1;
    tick();

    // ADEM alone
    ms_to_ws_valid = 1; ms_pc = 32'h1C00_0108; ms_vaddr = 32'h8003; ms_ex_adem = 1;
    tick();
    clr();
    step();
    chk("adem_esub", 32'(wb_esubcode), 32'h1);
    adv();

    // ERTN with an instruction arriving the same cycle: the arrival is dropped
    ms_to_ws_valid = 1; ms_ertn = 1; ertn_entry = 32'h1C00_0200;
    tick();
    clr(); ms_to_ws_valid = 1; ms_rf_we = 1; ms_rf_waddr = 5'd9; ms_csr_op = 2'd2;
    step();
    chk("ertn_target", flush_target, 32'h1C00_0200);
    adv();
    clr();
    tick();

    // Reset while WB holds a csrwr
    ms_to_ws_valid = 1; ms_csr_op = 2'd2; ms_rf_we = 1;
    tick();
    clr(); resetn = 0;
    tick();
    resetn = 1;
    tick();

    // 2^RW back-to-back retirements wrap the counter
    for (int i = 0; i < (1 << RW); i++) begin
      ms_to_ws_valid = 1; ms_pc = 32'h1C00_1000 + 32'(i * 4); ms_result = 32'(i);
      ms_rf_we = 1; ms_rf_waddr = 5'(i);
      tick();
    end
    clr();
    tick();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rand_in();
      tick();
    end
    resetn = 1; clr();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
